// File: rtl/stereo_gray_pkg.sv
// Shared types for the stereo gray scheduler: camera side IDs and packed RGB pixels.
package stereo_gray_pkg;
  localparam int PIX_W = 8;

  typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/gray_pix_fifo.sv
// Show-ahead synchronous FIFO of RGB pixels; push while full is accepted when the same cycle pops.
module gray_pix_fifo
  import stereo_gray_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rgb_t                   din,
  input  logic                   pop,
  output rgb_t                   dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  rgb_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array: contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/stereo_gray_scheduler.sv
// Round-robin share of one gray converter between left/right cameras with per-side result demux.
// Optional macro STEREO_GRAY_STATS_EN adds saturating 16-bit per-side drop counters.
module stereo_gray_scheduler
  import stereo_gray_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CONV_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_L_DVAL,
  input  logic [PIX_W-1:0] i_L_Red,
  input  logic [PIX_W-1:0] i_L_Green,
  input  logic [PIX_W-1:0] i_L_Blue,
  input  logic             i_R_DVAL,
  input  logic [PIX_W-1:0] i_R_Red,
  input  logic [PIX_W-1:0] i_R_Green,
  input  logic [PIX_W-1:0] i_R_Blue,
  output logic             o_conv_DVAL,
  output logic [PIX_W-1:0] o_conv_Red,
  output logic [PIX_W-1:0] o_conv_Green,
  output logic [PIX_W-1:0] o_conv_Blue,
  input  logic             i_conv_DVAL,
  input  logic [PIX_W-1:0] i_conv_gray,
  output logic             o_L_DVAL,
  output logic [PIX_W-1:0] o_L_gray,
  output logic             o_R_DVAL,
  output logic [PIX_W-1:0] o_R_gray,
  input  logic             i_clr_ovf,
  output logic             o_L_ovf,
  output logic             o_R_ovf
`ifdef STEREO_GRAY_STATS_EN
  ,
  output logic [15:0]      o_L_drop_cnt,
  output logic [15:0]      o_R_drop_cnt
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rgb_t                l_din, r_din, l_head, r_head, conv_pix;
  logic                l_empty, r_empty, l_full, r_full;
  logic [CNT_W-1:0]    l_count, r_count;
  logic                l_push, r_push, l_pop, r_pop, l_drop, r_drop;
  logic                any_rdy, hit;
  chan_t               prio, grant, tag_side;
  logic [CONV_LAT-1:0] tag_vld, tag_ch;

  assign l_din = {i_L_Red, i_L_Green, i_L_Blue};
  assign r_din = {i_R_Red, i_R_Green, i_R_Blue};

  gray_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_l (
    .clk(clk), .rst_n(rst_n), .push(l_push), .din(l_din), .pop(l_pop),
    .dout(l_head), .empty(l_empty), .full(l_full), .count(l_count)
  );

  gray_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk(clk), .rst_n(rst_n), .push(r_push), .din(r_din), .pop(r_pop),
    .dout(r_head), .empty(r_empty), .full(r_full), .count(r_count)
  );

  assign any_rdy = ~l_empty | ~r_empty;
  assign l_pop   = any_rdy & (grant == CH_L);
  assign r_pop   = any_rdy & (grant == CH_R);
  // A full FIFO still accepts when it pops in the same cycle.
  assign l_push  = i_L_DVAL & (~l_full | l_pop);
  assign r_push  = i_R_DVAL & (~r_full | r_pop);
  assign l_drop  = i_L_DVAL & (l_count == CNT_W'(FIFO_DEPTH)) & ~l_pop;
  assign r_drop  = i_R_DVAL & (r_count == CNT_W'(FIFO_DEPTH)) & ~r_pop;

  // Round-robin pick: prio names the side that wins a tie.
  always_comb begin
    if (!l_empty && !r_empty) grant = prio;
    else if (!r_empty)        grant = CH_R;
    else                      grant = CH_L;
  end

  // Issue mux toward the converter, zero when idle.
  always_comb begin
    if (!any_rdy)              conv_pix = '0;
    else if (grant == CH_L)    conv_pix = l_head;
    else                       conv_pix = r_head;
  end

  assign o_conv_DVAL  = any_rdy;
  assign o_conv_Red   = conv_pix.r;
  assign o_conv_Green = conv_pix.g;
  assign o_conv_Blue  = conv_pix.b;

  assign tag_side = chan_t'(tag_ch[CONV_LAT-1]);
  assign hit      = i_conv_DVAL & tag_vld[CONV_LAT-1];

  // Tie priority flips away from each grant; the tag pipe tracks converter latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= CH_L;
      tag_vld <= '0;
      tag_ch  <= '0;
    end else begin
      if (any_rdy) prio <= (grant == CH_L) ? CH_R : CH_L;
      tag_vld <= (tag_vld << 1) | CONV_LAT'(any_rdy);
      tag_ch  <= (tag_ch << 1)  | CONV_LAT'(grant == CH_R);
    end
  end

  // Result demux into per-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_L_DVAL <= 1'b0;
      o_R_DVAL <= 1'b0;
      o_L_gray <= '0;
      o_R_gray <= '0;
    end else begin
      o_L_DVAL <= hit & (tag_side == CH_L);
      o_R_DVAL <= hit & (tag_side == CH_R);
      if (hit && tag_side == CH_L) o_L_gray <= i_conv_gray;
      if (hit && tag_side == CH_R) o_R_gray <= i_conv_gray;
    end
  end

  // Sticky overflow flags; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_L_ovf <= 1'b0;
      o_R_ovf <= 1'b0;
    end else if (i_clr_ovf) begin
      o_L_ovf <= 1'b0;
      o_R_ovf <= 1'b0;
    end else begin
      o_L_ovf <= o_L_ovf | l_drop;
      o_R_ovf <= o_R_ovf | r_drop;
    end
  end

`ifdef STEREO_GRAY_STATS_EN
  // Saturating drop counters sharing the overflow clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_L_drop_cnt <= 16'h0000;
      o_R_drop_cnt <= 16'h0000;
    end else if (i_clr_ovf) begin
      o_L_drop_cnt <= 16'h0000;
      o_R_drop_cnt <= 16'h0000;
    end else begin
      if (l_drop && o_L_drop_cnt != 16'hFFFF) o_L_drop_cnt <= o_L_drop_cnt + 16'd1;
      if (r_drop && o_R_drop_cnt != 16'hFFFF) o_R_drop_cnt <= o_R_drop_cnt + 16'd1;
    end
  end
`endif
endmodule
